// File: rtl/cla_carry_stage.sv
// Two-register 4-bit carry-lookahead stage: stage A holds p/g/c0, stage B holds sums and carry-out.
// Optional macro CLA_GROUP_PG_EN adds registered group propagate (pg) and group generate (gg) outputs.
module cla_carry_stage (
  input  logic clk,
  input  logic rst,
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic g1,
  input  logic g2,
  input  logic g3,
  input  logic g4,
  input  logic c0,
  input  logic in_valid,
  output logic in_ready,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic c4,
  output logic out_valid,
  input  logic out_ready
`ifdef CLA_GROUP_PG_EN
  ,
  output logic pg,
  output logic gg
`endif
);

  // Handshake: a beat moves on any edge where valid & ready are both high;
  // a held result (out_valid & !out_ready) stays unchanged until accepted.
  logic [3:0] r_p;
  logic [3:0] r_g;
  logic       r_c0;
  logic       r_a_valid;
  logic [3:0] r_s;
  logic       r_c4;
  logic       r_out_valid;

  logic       w_b_adv;
  logic       w_capture;
  logic [4:0] w_c;
  logic [3:0] w_s;

  assign w_b_adv   = r_a_valid & (~r_out_valid | out_ready);
  assign in_ready  = ~r_a_valid | w_b_adv;
  assign w_capture = in_valid & in_ready;

  // Flat two-level lookahead; each carry depends only on stage A registers.
  assign w_c[0] = r_c0;
  assign w_c[1] = r_g[0] | (r_p[0] & r_c0);
  assign w_c[2] = r_g[1] | (r_p[1] & r_g[0]) | (r_p[1] & r_p[0] & r_c0);
  assign w_c[3] = r_g[2] | (r_p[2] & r_g[1]) | (r_p[2] & r_p[1] & r_g[0])
                | (r_p[2] & r_p[1] & r_p[0] & r_c0);
  assign w_c[4] = r_g[3] | (r_p[3] & r_g[2]) | (r_p[3] & r_p[2] & r_g[1])
                | (r_p[3] & r_p[2] & r_p[1] & r_g[0])
                | (r_p[3] & r_p[2] & r_p[1] & r_p[0] & r_c0);
  assign w_s    = r_p ^ w_c[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p       <= '0;
      r_g       <= '0;
      r_c0      <= 1'b0;
      r_a_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_p  <= {p4, p3, p2, p1};
        r_g  <= {g4, g3, g2, g1};
        r_c0 <= c0;
      end
      if (w_capture)    r_a_valid <= 1'b1;
      else if (w_b_adv) r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_c4        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_b_adv) begin
      r_s         <= w_s;
      r_c4        <= w_c[4];
      r_out_valid <= 1'b1;
    end else if (out_ready & r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CLA_GROUP_PG_EN
  logic w_pg;
  logic w_gg;
  logic r_pg;
  logic r_gg;

  assign w_pg = &r_p;
  assign w_gg = r_g[3] | (r_p[3] & r_g[2]) | (r_p[3] & r_p[2] & r_g[1])
              | (r_p[3] & r_p[2] & r_p[1] & r_g[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pg <= 1'b0;
      r_gg <= 1'b0;
    end else if (w_b_adv) begin
      r_pg <= w_pg;
      r_gg <= w_gg;
    end
  end

  assign pg = r_pg;
  assign gg = r_gg;
`endif

  assign {s4, s3, s2, s1} = r_s;
  assign c4               = r_c4;
  assign out_valid        = r_out_valid;

endmodule
